// File: rtl/usb_slavefifo_ctrl.sv
// FX2 (CY7C68013) slave-FIFO controller on IFCLK: one read endpoint into the RX cache and one
// write endpoint fed from the TX buffer RAM, arbitrated by a single state machine.
module usb_slavefifo_ctrl #(
  parameter int         DATA_W     = 16,
  parameter int         ADDR_W     = 9,
  parameter int         PKT_WORDS  = 256,
  parameter int         RX_BURST   = 256,
  parameter logic [1:0] RD_FIFOADR = 2'b00,
  parameter logic [1:0] WR_FIFOADR = 2'b10
) (
  input  logic              ifclk,
  input  logic              rst,
  input  logic              f_empty,
  input  logic              f_full,
  input  logic [DATA_W-1:0] rdata,
  output logic              sloe,
  output logic              slrd,
  output logic              slwr,
  output logic              pktend,
  output logic [1:0]        fifoaddr,
  output logic              wen,
  output logic [DATA_W-1:0] wdata,
  input  logic              rx_ready,
  output logic              rx_vd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_sop,
  output logic              rx_eop,
  input  logic              tx_req,
  input  logic [ADDR_W:0]   tx_len,
  output logic              tx_ack,
  output logic [ADDR_W-1:0] tx_addr,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_done,
  output logic              busy
);
  localparam int LEN_W   = ADDR_W + 1;
  localparam int BURST_W = $clog2(RX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RX_SEL = 3'd1,
    S_RX     = 3'd2,
    S_RX_END = 3'd3,
    S_TX_SEL = 3'd4,
    S_TX     = 3'd5,
    S_TX_END = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_ptr;
  logic [BURST_W-1:0] r_burst;
  logic               r_first;
  logic               r_rx_vd;
  logic               r_rx_sop;
  logic [DATA_W-1:0]  r_rx_data;
  logic               w_burst_hit;
  logic               w_last_word;
  logic               w_short;

  assign w_burst_hit = (r_burst == BURST_W'(RX_BURST));
  assign w_last_word = (r_ptr == (r_len - LEN_W'(1)));
  // Short or zero-length packets need PKTEND to commit them to the host.
  assign w_short     = (r_len == LEN_W'(0)) || ((int'(r_len) % PKT_WORDS) != 32'sd0);

  assign rx_vd   = r_rx_vd;
  assign rx_sop  = r_rx_sop;
  assign rx_data = r_rx_data;
  assign busy    = (r_state != S_IDLE);

  // Next-state and strobe decode; strobes follow the FX2 flags combinationally.
  always_comb begin
    w_next   = r_state;
    sloe     = 1'b0;
    slrd     = 1'b0;
    slwr     = 1'b0;
    pktend   = 1'b0;
    fifoaddr = RD_FIFOADR;
    wen      = 1'b0;
    wdata    = {DATA_W{1'b0}};
    tx_ack   = 1'b0;
    tx_addr  = r_ptr[ADDR_W-1:0];
    tx_done  = 1'b0;
    rx_eop   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tx_req) begin
          tx_ack = 1'b1;
          w_next = S_TX_SEL;
        end else if (!f_empty && rx_ready) begin
          w_next = S_RX_SEL;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RX_SEL: begin
        sloe   = 1'b1;
        w_next = S_RX;
      end
      S_RX: begin
        sloe = 1'b1;
        if (f_empty || !rx_ready || (w_burst_hit && tx_req)) begin
          w_next = S_RX_END;
        end else begin
          slrd   = 1'b1;
          w_next = S_RX;
        end
      end
      S_RX_END: begin
        rx_eop = 1'b1;
        w_next = S_IDLE;
      end
      S_TX_SEL: begin
        fifoaddr = WR_FIFOADR;
        wen      = 1'b1;
        tx_addr  = {ADDR_W{1'b0}};
        if (r_len == LEN_W'(0)) begin
          w_next = S_TX_END;
        end else if (!f_full) begin
          w_next = S_TX;
        end else begin
          w_next = S_TX_SEL;
        end
      end
      S_TX: begin
        fifoaddr = WR_FIFOADR;
        wen      = 1'b1;
        wdata    = tx_data;
        if (!f_full) begin
          slwr    = 1'b1;
          tx_addr = r_ptr[ADDR_W-1:0] + ADDR_W'(1);
          if (w_last_word) begin
            w_next = S_TX_END;
          end else begin
            w_next = S_TX;
          end
        end else begin
          w_next = S_TX;
        end
      end
      S_TX_END: begin
        fifoaddr = WR_FIFOADR;
        wen      = 1'b1;
        if (!w_short) begin
          tx_done = 1'b1;
          w_next  = S_IDLE;
        end else if (!f_full) begin
          pktend  = 1'b1;
          tx_done = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_next = S_TX_END;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register, RX capture pipeline and transfer counters.
  always_ff @(posedge ifclk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_len     <= LEN_W'(0);
      r_ptr     <= LEN_W'(0);
      r_burst   <= BURST_W'(0);
      r_first   <= 1'b0;
      r_rx_vd   <= 1'b0;
      r_rx_sop  <= 1'b0;
      r_rx_data <= {DATA_W{1'b0}};
    end else begin
      r_state  <= w_next;
      r_rx_vd  <= slrd;
      r_rx_sop <= slrd & r_first;
      if (slrd) begin
        r_rx_data <= rdata;
      end
      case (r_state)
        S_IDLE: begin
          r_ptr   <= LEN_W'(0);
          r_burst <= BURST_W'(0);
          r_first <= 1'b1;
          if (tx_req) begin
            r_len <= tx_len;
          end
        end
        S_RX: begin
          if (slrd) begin
            r_first <= 1'b0;
            if (!w_burst_hit) begin
              r_burst <= r_burst + BURST_W'(1);
            end
          end
        end
        S_TX: begin
          if (slwr) begin
            r_ptr <= r_ptr + LEN_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: doc/usb_slavefifo_ctrl.md
Name: usb_slavefifo_ctrl

Overview:
Parametrised successor controller for the CY7C68013 slave-FIFO port, clocked by the 48 MHz IFCLK. It arbitrates one read endpoint (host→FPGA) and one write endpoint (FPGA→host) through a single state machine. New over the previous generation:
- configurable data width and TX length;
- RX backpressure;
- bounded RX bursts so TX cannot starve;
- PKTEND on short or zero-length packets.

It sits between the FX2 pins and the RX cache / TX buffer RAM.

Parameters:
DATA_W, 16, FX2 data bus width (8 or 16).
ADDR_W, 9, TX buffer RAM address width.
PKT_WORDS, 256, words per full USB packet (512 B / 2).
RX_BURST, 256, maximum RX words per grant before TX may pre-empt.
RD_FIFOADR, 2'b00, FIFOADR code of the read endpoint.
WR_FIFOADR, 2'b10, FIFOADR code of the write endpoint.

Ports:
ifclk  in  1  IFCLK, all logic on rising edge.
rst  in  1  asynchronous active-high reset.
f_empty  in  1  read-endpoint empty flag, 1 = empty.
f_full  in  1  write-endpoint full flag, 1 = full.
rdata  in  DATA_W  FD bus input.
sloe  out  1  SLOE, 1 = FX2 drives FD.
slrd  out  1  SLRD strobe, 1 = read.
slwr  out  1  SLWR strobe, 1 = write.
pktend  out  1  PKTEND strobe.
fifoaddr  out  2  FIFOADR[1:0].
wen  out  1  FPGA tristate enable for FD.
wdata  out  DATA_W  FD bus output.
rx_ready  in  1  RX cache can accept data.
rx_vd  out  1  rx_data valid.
rx_data  out  DATA_W  received word.
rx_sop  out  1  with first rx_vd of a burst.
rx_eop  out  1  single-cycle end-of-burst marker, rx_vd=0.
tx_req  in  1  TX buffer holds tx_len words.
tx_len  in  ADDR_W+1  words to send, 0 to 2^ADDR_W.
tx_ack  out  1  1-cycle pulse: request accepted, tx_len latched.
tx_addr  out  ADDR_W  TX RAM read address; RAM has 1-cycle latency.
tx_data  in  DATA_W  RAM output for the address issued the previous cycle.
tx_done  out  1  1-cycle pulse at end of transfer.
busy  out  1  state != IDLE.

Behaviour:
Reset (asynchronous, any state):
- state=IDLE; every strobe, rx_* and tx_* output = 0.
- fifoaddr=RD_FIFOADR; wen=0; counters cleared.
- A transfer in flight is abandoned: no rx_eop, no tx_done.

States:
- IDLE:
  - fifoaddr=RD_FIFOADR; sloe=wen=0.
  - If tx_req: go TX_SEL, pulse tx_ack, latch tx_len. TX has priority when both are pending.
  - Else if !f_empty and rx_ready: go RX_SEL.
- RX_SEL:
  - sloe=1; go RX next cycle. This is the bus turnaround cycle.
- RX:
  - sloe=1; slrd = !f_empty & rx_ready.
  - Each edge with slrd=1 captures rdata. Next cycle: rx_vd=1, rx_data = captured word (latency 1).
  - rx_sop accompanies the first rx_vd after RX_SEL.
  - Burst counter counts slrd cycles.
  - Exit to RX_END when any of:
    - f_empty=1;
    - rx_ready=0 for 1 cycle;
    - counter = RX_BURST with tx_req=1.
- RX_END:
  - sloe=0; rx_eop=1 for 1 cycle; go IDLE.
  - The IDLE cycle guarantees ≥1 cycle with sloe=wen=0 before any FPGA drive.
- TX_SEL:
  - fifoaddr=WR_FIFOADR; wen=1.
  - tx_addr=0 issued (prefetch); word counter=0.
  - If latched len = 0: go TX_END.
  - Else if !f_full: go TX.
- TX:
  - wen=1; wdata=tx_data; slwr = !f_full.
  - tx_addr = ptr + slwr, combinational look-ahead. ptr advances on slwr, so a stall holds the data word.
  - On slwr with counter = len-1: go TX_END.
- TX_END:
  - wen=1.
  - pktend=1 for 1 cycle, only when len mod PKT_WORDS != 0 or len = 0 (zero-length packet). Asserted only when f_full=0, otherwise the state waits.
  - tx_done=1 on the exit cycle; then go IDLE, wen=0.

Invariants:
- slrd and slwr are never both 1.
- sloe and wen are never both 1.
- fifoaddr is stable while any strobe is asserted.

Test Plan:
1. RX only: 5 words 0x0001..0x0005 in FX2, rx_ready=1 → RX_SEL, 5 slrd; rx_vd×5 in order; rx_sop on the first; rx_eop 1 cycle after the last; no pktend.
2. RX backpressure: rx_ready drops after word 3 of 8 → slrd stops the same cycle, rx_eop; on rx_ready re-assertion a new burst starts with rx_sop at word 4; all 8 words delivered once, in order.
3. TX full packet: tx_len=256, f_full=0 → tx_ack; 256 slwr; wdata = RAM[0..255]; no pktend; tx_done.
4. TX short packet with stall: tx_len=10, f_full=1 for 3 cycles after word 4 → slwr=0 and wdata held = RAM[4] during the stall; 10 words in order; pktend 1 pulse; tx_done.
5. Arbitration: RX busy with 1000 words pending, tx_req at word 20 → RX exits at word 256, rx_eop, IDLE, TX completes, RX resumes; sloe/wen never overlap.
6. tx_len=0 → tx_ack, 0 slwr, pktend 1 pulse (ZLP), tx_done. rst asserted mid-TX word 7 → all outputs 0 asynchronously, no tx_done; new request after release starts at addr 0.
